// File: rtl/double_shift_right_64bit.sv
// Registered 64-bit funnel right shifter: y = low word of ({a,b} >> sa).
// Five-level log shifter, big-endian bit numbering throughout.
module double_shift_right_64bit (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [0:31] a,
  input  logic [0:31] b,
  input  logic [0:4]  sa,
  output logic [0:31] y,
  output logic        y_valid
);

  logic [0:63] w_l0;
  logic [0:63] w_l1;
  logic [0:63] w_l2;
  logic [0:63] w_l3;
  logic [0:63] w_l4;
  logic [0:63] w_l5;
  logic [0:31] w_r;

  logic [0:31] r_y;
  logic        r_y_valid;

  // sa bit 0 is the MSB, so it drives the 16-bit stage.
  assign w_l0 = {a, b};
  assign w_l1 = sa[0] ? {16'd0, w_l0[0:47]} : w_l0;
  assign w_l2 = sa[1] ? {8'd0,  w_l1[0:55]} : w_l1;
  assign w_l3 = sa[2] ? {4'd0,  w_l2[0:59]} : w_l2;
  assign w_l4 = sa[3] ? {2'd0,  w_l3[0:61]} : w_l3;
  assign w_l5 = sa[4] ? {1'b0,  w_l4[0:62]} : w_l4;
  assign w_r  = w_l5[32:63];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_y       <= '0;
      r_y_valid <= 1'b0;
    end else if (en) begin
      r_y       <= w_r;
      r_y_valid <= 1'b1;
    end else begin
      r_y_valid <= 1'b0;
    end
  end

  assign y       = r_y;
  assign y_valid = r_y_valid;

endmodule

// File: tb/tb_double_shift_right_64bit.sv
// Directed bench for double_shift_right_64bit.
// Hand-computed vectors, one checking task.
module tb_double_shift_right_64bit;

  logic        clk;
  logic        rst;
  logic        en;
  logic [0:31] a;
  logic [0:31] b;
  logic [0:4]  sa;
  logic [0:31] y;
  logic        y_valid;

  int n_chk;
  int n_err;

  double_shift_right_64bit dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .a       (a),
    .b       (b),
    .sa      (sa),
    .y       (y),
    .y_valid (y_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cap(input logic [31:0] ia,
                     input logic [31:0] ib,
                     input logic [4:0]  isa);
    a  = ia;
    b  = ib;
    sa = isa;
    en = 1'b1;
    step();
  endtask

  logic [31:0] held;

  initial begin
    n_chk = 0;
    n_err = 0;
    rst = 1'b1;
    en  = 1'b0;
    a   = '0;
    b   = '0;
    sa  = '0;
    step();
    step();
    chk("rst_y", y, 32'h0);
    chk("rst_v", {31'd0, y_valid}, 32'd0);

    rst = 1'b0;
    cap(32'h0000FF0F, 32'h00000FFF, 5'd5);
    chk("basic_y", y, 32'h7800007F);
    chk("basic_v", {31'd0, y_valid}, 32'd1);

    // back-to-back captures, one result per cycle
    cap(32'h12345678, 32'h9ABCDEF0, 5'd0);
    chk("sa0", y, 32'h9ABCDEF0);
    chk("sa0_v", {31'd0, y_valid}, 32'd1);
    cap(32'h12345678, 32'h9ABCDEF0, 5'd16);
    chk("sa16", y, 32'h56789ABC);
    cap(32'h12345678, 32'h9ABCDEF0, 5'd31);
    chk("sa31", y, 32'h2468ACF1);
    cap(32'h12345678, 32'h9ABCDEF0, 5'd1);
    chk("sa1", y, 32'h4D5E6F78);
    cap(32'h12345678, 32'h9ABCDEF0, 5'd4);
    chk("sa4", y, 32'h89ABCDEF);
    cap(32'h12345678, 32'h9ABCDEF0, 5'd8);
    chk("sa8", y, 32'h789ABCDE);
    cap(32'h12345678, 32'h9ABCDEF0, 5'd2);
    chk("sa2", y, 32'h26AF37BC);
    cap(32'h80000001, 32'h80000001, 5'd1);
    chk("rot1", y, 32'hC0000000);
    chk("rot1_v", {31'd0, y_valid}, 32'd1);

    // hold with en low
    held = 32'hC0000000;
    en = 1'b0;
    a  = 32'hDEADBEEF;
    b  = 32'hCAFEF00D;
    sa = 5'd7;
    step();
    chk("hold_y", y, held);
    chk("hold_v", {31'd0, y_valid}, 32'd0);
    step();
    chk("hold2_y", y, held);

    // reset wins over en
    rst = 1'b1;
    en  = 1'b1;
    a   = 32'hFFFFFFFF;
    b   = 32'hFFFFFFFF;
    sa  = 5'd3;
    step();
    chk("rstpri_y", y, 32'h0);
    chk("rstpri_v", {31'd0, y_valid}, 32'd0);

    rst = 1'b0;
    cap(32'h0000FF0F, 32'h00000FFF, 5'd5);
    chk("post_y", y, 32'h7800007F);
    chk("post_v", {31'd0, y_valid}, 32'd1);
    en = 1'b0;
    step();
    chk("post_v0", {31'd0, y_valid}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
